// File: rtl/des_pkg.sv
// Shared constants for the DES CBC chaining controller.
package des_pkg;

    localparam int BLK_W = 64;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/des_cbc_ctrl.sv
// CBC chaining controller driving a DES core's key/data/valid interface.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int MAX_LAT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [0:BLK_W-1] key_i,
    input  logic [0:BLK_W-1] iv_i,
    input  logic [0:BLK_W-1] data_i,
    input  logic             valid_i,
    output logic             accept_o,
    output logic [0:BLK_W-1] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             error_o,
    output logic             des_mode_o,
    output logic [0:BLK_W-1] des_key_o,
    output logic [0:BLK_W-1] des_data_o,
    output logic             des_valid_o,
    input  logic [0:BLK_W-1] des_data_i,
    input  logic             des_valid_i
);

    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((MAX_LAT == 0) ? 0 : MAX_LAT - 1);

    state_e           state_q, state_d;
    logic [0:BLK_W-1] chain_q, chain_d;
    logic [0:BLK_W-1] key_q, key_d;
    logic             mode_q, mode_d;
    logic [0:BLK_W-1] ct_hold_q, ct_hold_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             accept_q, accept_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [0:BLK_W-1] data_q, data_d;
    logic             des_valid_q, des_valid_d;
    logic             des_mode_q, des_mode_d;
    logic [0:BLK_W-1] des_key_q, des_key_d;
    logic [0:BLK_W-1] des_data_q, des_data_d;

    always_comb begin
        state_d     = state_q;
        chain_d     = chain_q;
        key_d       = key_q;
        mode_d      = mode_q;
        ct_hold_d   = ct_hold_q;
        wd_d        = wd_q;
        error_d     = error_q;
        data_d      = data_q;
        des_valid_d = 1'b0;
        des_mode_d  = des_mode_q;
        des_key_d   = des_key_q;
        des_data_d  = des_data_q;

        unique case (state_q)
            ST_IDLE, ST_READY: begin
                // a new chain always wins over a pending block
                if (start_i) begin
                    key_d   = key_i;
                    chain_d = iv_i;
                    mode_d  = mode_i;
                    error_d = 1'b0;
                    state_d = ST_READY;
                end else if (state_q == ST_READY && valid_i) begin
                    state_d     = ST_BUSY;
                    des_valid_d = 1'b1;
                    des_key_d   = key_q;
                    des_mode_d  = mode_q;
                    wd_d        = '0;
                    if (mode_q == MODE_DEC) begin
                        des_data_d = data_i;
                        ct_hold_d  = data_i;
                    end else begin
                        des_data_d = data_i ^ chain_q;
                    end
                end
            end
            ST_BUSY: begin
                wd_d = wd_q + CNT_W'(1);
                if (des_valid_i) begin
                    state_d = ST_OUT;
                    if (mode_q == MODE_DEC) begin
                        data_d  = des_data_i ^ chain_q;
                        chain_d = ct_hold_q;
                    end else begin
                        data_d  = des_data_i;
                        chain_d = des_data_i;
                    end
                end else if (MAX_LAT != 0 && wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (ready_i) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        accept_d = (state_d == ST_READY);
        valid_d  = (state_d == ST_OUT);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            chain_q     <= '0;
            key_q       <= '0;
            mode_q      <= MODE_ENC;
            ct_hold_q   <= '0;
            wd_q        <= '0;
            accept_q    <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            data_q      <= '0;
            des_valid_q <= 1'b0;
            des_mode_q  <= 1'b0;
            des_key_q   <= '0;
            des_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            ct_hold_q   <= ct_hold_d;
            wd_q        <= wd_d;
            accept_q    <= accept_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            data_q      <= data_d;
            des_valid_q <= des_valid_d;
            des_mode_q  <= des_mode_d;
            des_key_q   <= des_key_d;
            des_data_q  <= des_data_d;
        end
    end

    assign accept_o    = accept_q;
    assign valid_o     = valid_q;
    assign error_o     = error_q;
    assign data_o      = data_q;
    assign des_valid_o = des_valid_q;
    assign des_mode_o  = des_mode_q;
    assign des_key_o   = des_key_q;
    assign des_data_o  = des_data_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Randomized bench for des_cbc_ctrl with a behavioural core and CBC model.
module tb_des_cbc_ctrl;

    localparam logic [63:0] KEY_TV = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_TV  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_TV  = 64'h85E813540F0AB405;
    localparam logic [63:0] TOY_C  = 64'hA5A5_3C3C_0FF0_9669;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [63:0] key_i = '0;
    logic [63:0] iv_i = '0;
    logic [63:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        accept_o;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        error_o;
    logic        des_mode_o;
    logic [63:0] des_key_o;
    logic [63:0] des_data_o;
    logic        des_valid_o;
    logic [63:0] des_data_i;
    logic        des_valid_i;

    logic        core_vld = 1'b0;
    logic [63:0] core_dat = '0;
    logic        stray_vld = 1'b0;
    logic [63:0] stray_dat = '0;
    bit          core_en = 1'b1;
    int          lat_cfg = 2;
    int          cnt = 0;
    logic [63:0] res = '0;
    logic [63:0] last_in = '0;
    int          pulses = 0;

    int n_chk = 0;
    int n_err = 0;

    assign des_valid_i = core_vld | stray_vld;
    assign des_data_i  = stray_vld ? stray_dat : core_dat;

    des_cbc_ctrl #(.MAX_LAT(64), .CNT_W(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .key_i       (key_i),
        .iv_i        (iv_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .accept_o    (accept_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .error_o     (error_o),
        .des_mode_o  (des_mode_o),
        .des_key_o   (des_key_o),
        .des_data_o  (des_data_o),
        .des_valid_o (des_valid_o),
        .des_data_i  (des_data_i),
        .des_valid_i (des_valid_i)
    );

    always #5 clk = ~clk;

    // stand-in cipher: real DES on the known vector, invertible toy otherwise
    function automatic logic [63:0] toy_e(logic [63:0] k, logic [63:0] x);
        logic [63:0] y;
        y = x ^ k;
        return ((y << 11) | (y >> 53)) ^ TOY_C;
    endfunction

    function automatic logic [63:0] toy_d(logic [63:0] k, logic [63:0] x);
        logic [63:0] y;
        y = x ^ TOY_C;
        return ((y >> 11) | (y << 53)) ^ k;
    endfunction

    function automatic logic [63:0] cipher(logic m, logic [63:0] k,
                                           logic [63:0] d);
        if (k == KEY_TV && !m && d == PT_TV) return CT_TV;
        if (k == KEY_TV && m && d == CT_TV) return PT_TV;
        return m ? toy_d(k, d) : toy_e(k, d);
    endfunction

    always @(negedge clk) begin
        core_vld = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                core_vld = core_en;
                core_dat = res;
            end
        end
        if (des_valid_o) begin
            pulses  = pulses + 1;
            last_in = des_data_o;
            res     = cipher(des_mode_o, des_key_o, des_data_o);
            cnt     = lat_cfg;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input logic m, input logic [63:0] k,
                            input logic [63:0] iv);
        start_i = 1'b1;
        mode_i  = m;
        key_i   = k;
        iv_i    = iv;
        step();
        start_i = 1'b0;
        check("start_accept", 64'(accept_o), 64'd1);
    endtask

    task automatic send_block(input logic [63:0] din, input int hold,
                              output logic [63:0] dout);
        bit ok;
        int p0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (accept_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("accept_wait", 64'd0, 64'd1);
        p0      = pulses;
        data_i  = din;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("des_pulse", 64'(des_valid_o), 64'd1);
        step();
        check("des_pulse_single", 64'(des_valid_o), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("result_wait", 64'd0, 64'd1);
        dout = data_o;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_data", data_o, dout);
            check("hold_valid", 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("valid_drop", 64'(valid_o), 64'd0);
        check("pulse_count", 64'(pulses - p0), 64'd1);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] key;
        logic [63:0] iv;
        logic [63:0] iv2;
        logic [63:0] prev;
        logic [63:0] pt[4];
        logic [63:0] ct[4];

        repeat (3) step();
        check("rst_accept", 64'(accept_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_des_valid", 64'(des_valid_o), 64'd0);
        check("rst_data", data_o, 64'd0);
        check("rst_des_data", des_data_o, 64'd0);
        check("rst_des_key", des_key_o, 64'd0);
        check("rst_des_mode", 64'(des_mode_o), 64'd0);
        reset_i = 1'b1;
        step();
        check("idle_accept", 64'(accept_o), 64'd0);

        // known vectors; second block exercises the updated chain
        do_start(1'b0, KEY_TV, 64'd0);
        send_block(PT_TV, 0, r);
        check("enc_tv", r, CT_TV);
        check("enc_tv_core_in", last_in, PT_TV);
        send_block(CT_TV ^ PT_TV, 0, r);
        check("enc_chain", r, CT_TV);
        check("enc_chain_core_in", last_in, PT_TV);

        do_start(1'b0, KEY_TV, PT_TV);
        send_block(64'd0, 0, r);
        check("enc_iv_fold", r, CT_TV);

        do_start(1'b1, KEY_TV, 64'hFFFF_FFFF_FFFF_FFFF);
        send_block(CT_TV, 0, r);
        check("dec_tv", r, 64'hFEDCBA9876543210);
        check("dec_tv_core_in", last_in, CT_TV);
        send_block(CT_TV, 0, r);
        check("dec_chain", r, PT_TV ^ CT_TV);

        // start beats a simultaneous block
        key = {$urandom, $urandom};
        if (key == KEY_TV) key[0] = ~key[0];
        do_start(1'b0, key, {$urandom, $urandom});
        iv2 = {$urandom, $urandom};
        pt[0] = {$urandom, $urandom};
        start_i = 1'b1;
        iv_i    = iv2;
        valid_i = 1'b1;
        data_i  = pt[0];
        step();
        start_i = 1'b0;
        check("prio_no_pulse", 64'(des_valid_o), 64'd0);
        check("prio_accept", 64'(accept_o), 64'd1);
        step();
        valid_i = 1'b0;
        check("prio_pulse", 64'(des_valid_o), 64'd1);
        check("prio_core_in", des_data_o, pt[0] ^ iv2);
        check("prio_key", des_key_o, key);
        for (int i = 0; i < 20 && !valid_o; i++) step();
        check("prio_result", data_o, toy_e(key, pt[0] ^ iv2));
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;

        // random round trip with backpressure and random core latency
        iv = {$urandom, $urandom};
        do_start(1'b0, key, iv);
        prev = iv;
        for (int i = 0; i < 4; i++) begin
            pt[i]   = {$urandom, $urandom};
            lat_cfg = int'($urandom_range(1, 6));
            send_block(pt[i], 5, ct[i]);
            check("rt_enc", ct[i], toy_e(key, pt[i] ^ prev));
            prev = toy_e(key, pt[i] ^ prev);
        end
        do_start(1'b1, key, iv);
        for (int i = 0; i < 4; i++) begin
            lat_cfg = int'($urandom_range(1, 6));
            send_block(ct[i], 5, r);
            check("rt_dec", r, pt[i]);
        end

        // watchdog
        core_en = 1'b0;
        do_start(1'b0, key, iv);
        valid_i = 1'b1;
        data_i  = pt[1];
        step();
        valid_i = 1'b0;
        check("wd_pulse", 64'(des_valid_o), 64'd1);
        repeat (63) step();
        check("wd_not_yet", 64'(error_o), 64'd0);
        step();
        check("wd_error", 64'(error_o), 64'd1);
        check("wd_idle", 64'(accept_o), 64'd0);
        core_en = 1'b1;
        stray_dat = 64'h1234;
        stray_vld = 1'b1;
        step();
        stray_vld = 1'b0;
        step();
        check("wd_stray", 64'(valid_o), 64'd0);
        check("wd_sticky", 64'(error_o), 64'd1);
        do_start(1'b0, key, iv);
        check("wd_clear", 64'(error_o), 64'd0);

        // reset while a block is in flight
        lat_cfg = 6;
        valid_i = 1'b1;
        data_i  = pt[2];
        step();
        valid_i = 1'b0;
        check("rst_mid_pulse", 64'(des_valid_o), 64'd1);
        step();
        reset_i = 1'b0;
        #1;
        check("rst_mid_valid", 64'(valid_o), 64'd0);
        check("rst_mid_accept", 64'(accept_o), 64'd0);
        check("rst_mid_des_key", des_key_o, 64'd0);
        check("rst_mid_des_data", des_data_o, 64'd0);
        check("rst_mid_data", data_o, 64'd0);
        step();
        step();
        reset_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rst_late_result", 64'(valid_o), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
- CBC-mode chaining controller that acts as the initiator for the DES core's key/data/valid interface.
- It drives the core's inputs, consumes its result, and applies the CBC XOR and chaining-register update for both directions.
- It sits between a streaming block source/sink and the DES core at the crypto subsystem top level.
- It keeps one block in flight and is independent of the core's latency.

Parameters:
- MAX_LAT, 64, maximum cycles to wait for des_valid_i after issuing a block before flagging error_o; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must satisfy 2**CNT_W > MAX_LAT.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  load key_i/iv_i/mode_i and open a new chain.
- mode_i  in  1  0 = CBC encrypt, 1 = CBC decrypt; sampled with start_i.
- key_i  in  [0:63]  DES key; sampled with start_i.
- iv_i  in  [0:63]  initialisation vector; sampled with start_i.
- data_i  in  [0:63]  input block (plaintext or ciphertext).
- valid_i  in  1  input block valid.
- accept_o  out  1  controller can take a block.
- data_o  out  [0:63]  CBC result block.
- valid_o  out  1  result valid; held until ready_i.
- ready_i  in  1  sink accepts data_o.
- error_o  out  1  sticky core-timeout flag; cleared by start_i.
- des_mode_o  out  1  to core mode_i.
- des_key_o  out  [0:63]  to core key_i.
- des_data_o  out  [0:63]  to core data_i.
- des_valid_o  out  1  to core valid_i; single-cycle pulse.
- des_data_i  in  [0:63]  from core data_o.
- des_valid_i  in  1  from core valid_o.

Behaviour:
- Reset (reset_i low, async): state IDLE.
  - All outputs are 0: accept_o, valid_o, error_o, des_valid_o, data_o, des_data_o, des_key_o, des_mode_o.
  - Chain, key and ciphertext-hold registers are cleared.
- Registers: chain[0:63], key[0:63], mode, ct_hold[0:63], watchdog counter wd[CNT_W-1:0].
- States: IDLE, READY, BUSY, OUT.
- IDLE:
  - accept_o = 0.
  - On start_i: key <= key_i, chain <= iv_i, mode <= mode_i, error_o <= 0; go to READY.
- READY:
  - accept_o = 1 (registered).
  - start_i has priority: it reloads as in IDLE, no block is taken, and the source must hold valid_i.
  - A block is accepted when valid_i & !start_i; on acceptance go to BUSY.
    - Next cycle, des_valid_o = 1 for exactly one cycle.
    - des_key_o = key, des_mode_o = mode, wd <= 0.
    - Encrypt: des_data_o = data_i ^ chain.
    - Decrypt: des_data_o = data_i, ct_hold <= data_i.
- BUSY:
  - accept_o = 0; wd increments each cycle.
  - On des_valid_i:
    - Encrypt: data_o <= des_data_i, chain <= des_data_i.
    - Decrypt: data_o <= des_data_i ^ chain, chain <= ct_hold.
    - Assert valid_o and go to OUT.
  - If MAX_LAT != 0 and wd reaches MAX_LAT without des_valid_i: error_o <= 1, go to IDLE. A later stray des_valid_i is ignored.
  - start_i is ignored in BUSY and OUT.
- OUT:
  - valid_o = 1, data_o stable.
  - On ready_i: valid_o <= 0, go to READY. accept_o is 1 the following cycle, so the minimum gap between result and next accept is 1 cycle.
- des_valid_i outside BUSY is ignored.
- Chain continues across blocks until the next start_i; there is no block count limit.
- Key, data and des_data_o are driven from registers; the core inputs are stable from the des_valid_o pulse onward.
- Throughput: one block per (core latency + 3) cycles with ready_i held high.
- Reset mid-operation aborts the chain; an in-flight core result arriving after reset is ignored (state IDLE).

Decomposition:
- Shared package des_pkg holds:
  - state encoding constants (IDLE, READY, BUSY, OUT);
  - mode constants MODE_ENC = 0, MODE_DEC = 1;
  - block width constant 64.
- No sub-module: the DES core is instantiated beside this controller at the subsystem top, and the XOR/chain datapath stays inline.

Test Plan:
- Encrypt, IV=0: start with key 133457799BBCDFF1, mode 0, then block 0123456789ABCDEF -> data_o = 85E813540F0AB405, chain = 85E813540F0AB405.
- Encrypt, IV folding: same key, IV 0123456789ABCDEF, block 0000000000000000 -> data_o = 85E813540F0AB405.
- Decrypt: same key, mode 1, IV FFFFFFFFFFFFFFFF, block 85E813540F0AB405 -> data_o = FEDCBA9876543210, chain = 85E813540F0AB405.
- Round trip with backpressure:
  - Stimulus: encrypt 4 random blocks with a random IV, holding ready_i low 5 cycles on each result; then decrypt those results with the same IV.
  - Response: the original 4 blocks are recovered; data_o stays stable while ready_i is low; exactly one des_valid_o pulse per block.
- Timeout: core model never asserts des_valid_i, MAX_LAT=64 -> error_o = 1 and state IDLE 64 cycles after des_valid_o; next start_i clears error_o.
- Priority and reset:
  - start_i with valid_i in READY -> no des_valid_o, chain = new iv_i.
  - reset_i low during BUSY -> all outputs 0 immediately, and a late des_valid_i produces no valid_o.
